lab3_converter_state_diagram: RTL and testbench



---
 rtl/lab3_converter_state_diagram.sv | 77 +++++++
 tb/tb_lab3_converter_state_diagram.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lab3_converter_state_diagram.sv
// Bit-serial Excess-3 to BCD converter.
// Mealy FSM subtracting 0011 LSB-first with borrow.
module lab3_converter_state_diagram (
    input  logic X,
    input  logic Clk,
    input  logic Rst,
    output logic Z
);

    // Sn encodes bit position and pending borrow
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   z_d;

    // State register, async reset to start of digit
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Mealy output from state and X
    always_comb begin
        state_d = S0;
        z_d     = 1'b0;
        case (state_q)
            S0: begin
                z_d     = ~X;
                state_d = X ? S1 : S2;
            end
            S1: begin
                z_d     = ~X;
                state_d = X ? S3 : S4;
            end
            S2: begin
                z_d     = X;
                state_d = S4;
            end
            S3: begin
                z_d     = X;
                state_d = S5;
            end
            S4: begin
                z_d     = ~X;
                state_d = X ? S5 : S6;
            end
            S5: begin
                z_d     = X;
                state_d = S0;
            end
            S6: begin
                z_d     = ~X;
                state_d = S0;
            end
            default: begin
                z_d     = 1'b0;
                state_d = S0;
            end
        endcase
    end

    // Output is held low for the whole reset interval
    assign Z = Rst ? 1'b0 : z_d;

endmodule

// File: tb/tb_lab3_converter_state_diagram.sv
// Directed bench for the Excess-3 to BCD converter.
// X driven after rising edge, Z sampled at falling edge.
module tb_lab3_converter_state_diagram;

    logic X;
    logic Clk;
    logic Rst;
    logic Z;

    int n_checks;
    int n_pass;

    lab3_converter_state_diagram dut (
        .X  (X),
        .Clk(Clk),
        .Rst(Rst),
        .Z  (Z)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [3:0] obs,
                         input logic [3:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one bit, sample Z before the consuming edge
    task automatic send_bit(input logic b, output logic z);
        X = b;
        @(negedge Clk);
        z = Z;
        @(posedge Clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] e, output logic [3:0] r);
        logic zb;
        for (int i = 0; i < 4; i++) begin
            send_bit(e[i], zb);
            r[i] = zb;
        end
    endtask

    logic [3:0] res;
    logic [3:0] e;
    logic       zb;

    // Directed vectors: {excess-3 input, expected BCD}
    logic [7:0] vec [] = '{
        8'b0011_0000, 8'b0100_0001, 8'b0101_0010, 8'b0110_0011,
        8'b0111_0100, 8'b1000_0101, 8'b1001_0110, 8'b1010_0111,
        8'b1011_1000, 8'b1100_1001
    };

    logic [7:0] bad [] = '{
        8'b0000_1101, 8'b0001_1110, 8'b1111_1100, 8'b1101_1010,
        8'b0010_1111, 8'b1110_1011
    };

    initial begin
        n_checks = 0;
        n_pass   = 0;
        X        = 1'b0;
        Rst      = 1'b1;

        // Reset held: Z low regardless of X and clock
        for (int i = 0; i < 4; i++) begin
            X = i[0];
            @(negedge Clk);
            check("rst_hold", {3'b0, Z}, 4'b0000);
            #2;
            X = ~X;
            #1;
            check("rst_hold_x", {3'b0, Z}, 4'b0000);
        end
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        send_digit(4'b0011, res);
        check("after_rst_0011", res, 4'b0000);

        // Legal sweep, back-to-back
        foreach (vec[i]) begin
            send_digit(vec[i][7:4], res);
            check("legal", res, vec[i][3:0]);
        end

        // Illegal codes wrap, then a legal digit
        foreach (bad[i]) begin
            send_digit(bad[i][7:4], res);
            check("illegal", res, bad[i][3:0]);
        end
        send_digit(4'b0111, res);
        check("legal_after_bad", res, 4'b0100);

        // Mid-digit reset after two bits
        send_bit(1'b1, zb);
        send_bit(1'b0, zb);
        #2;
        Rst = 1'b1;
        X   = 1'b1;
        #1;
        check("mid_rst_x1", {3'b0, Z}, 4'b0000);
        X = 1'b0;
        #1;
        check("mid_rst_x0", {3'b0, Z}, 4'b0000);
        @(posedge Clk);
        #1;
        check("mid_rst_edge", {3'b0, Z}, 4'b0000);
        Rst = 1'b0;
        send_digit(4'b1001, res);
        check("after_mid_rst", res, 4'b0110);

        // Random legal stream, no gaps
        for (int i = 0; i < 10000; i++) begin
            e = 4'($urandom_range(12, 3));
            send_digit(e, res);
            check("random", res, e - 4'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
